// File: rtl/up_down_counter_sync.sv
// up_down_counter_sync: modulo-MODULUS up/down counter with parallel load and J/K drive for an external JK bank
// Ports:
//   clock_pos      rising-edge clock
//   reset_neg      synchronous active-low reset (count 0, no carry)
//   load_neg       synchronous active-low parallel load of load_value (clamped to MODULUS-1)
//   load_value     value to load
//   count_enable   advance the count when high
//   count_up       1 increments, 0 decrements
//   count_out      registered count
//   terminal_count combinational: the next enabled step wraps
//   carry_pulse    registered one-cycle pulse following a wrap
//   signal_J       per-bit J for the external JK bank (next-state of this edge)
//   signal_K       per-bit K for the external JK bank (next-state of this edge)
module up_down_counter_sync #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clock_pos,
   input  logic             reset_neg,
   input  logic             load_neg,
   input  logic [WIDTH-1:0] load_value,
   input  logic             count_enable,
   input  logic             count_up,
   output logic [WIDTH-1:0] count_out,
   output logic             terminal_count,
   output logic             carry_pulse,
   output logic [WIDTH-1:0] signal_J,
   output logic [WIDTH-1:0] signal_K
);
   localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULUS - 1);
   logic [WIDTH-1:0] clamped;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] toggle;
   logic             at_top;
   logic             at_bot;
   always_comb begin
      clamped        = (load_value > max_val) ? max_val : load_value;
      at_top         = count_out == max_val;
      at_bot         = count_out == '0;
      step           = count_up ? (at_top ? '0 : count_out + 1'b1) : (at_bot ? max_val : count_out - 1'b1);
      toggle         = count_out ^ step;
      terminal_count = reset_neg & load_neg & count_enable & (count_up ? at_top : at_bot);
      // Load drives J=value, K=~value so every bit is forced, independent of the bank's current state
      signal_J       = !reset_neg ? '0 : !load_neg ? clamped  : count_enable ? toggle : '0;
      signal_K       = !reset_neg ? '1 : !load_neg ? ~clamped : count_enable ? toggle : '0;
   end
   always_ff @(posedge clock_pos) begin
      if (!reset_neg) begin
         count_out   <= '0;
         carry_pulse <= 1'b0;
      end else begin
         count_out   <= !load_neg ? clamped : count_enable ? step : count_out;
         // terminal_count is already gated off by load, so a load never signals a wrap
         carry_pulse <= terminal_count;
      end
   end
endmodule

// File: tb/tb_up_down_counter_sync.sv
// tb_up_down_counter_sync: scoreboard bench for up_down_counter_sync (WIDTH=4, MODULUS=10) with a modelled JK bank
module tb_up_down_counter_sync;
   logic       clock_pos = 1'b0;
   logic       reset_neg = 1'b0;
   logic       load_neg = 1'b1;
   logic [3:0] load_value = '0;
   logic       count_enable = 1'b0;
   logic       count_up = 1'b1;
   logic [3:0] count_out;
   logic       terminal_count;
   logic       carry_pulse;
   logic [3:0] signal_J;
   logic [3:0] signal_K;
   logic [3:0] bank = '0;

   typedef struct {
      logic       tc;
      logic       jchk;
      logic [3:0] j;
      logic [3:0] k;
      logic [3:0] cnt;
      logic       car;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   wraps = 0;
   int   car_seen = 0;
   int   mc = 0;

   up_down_counter_sync #(.WIDTH(4), .MODULUS(10)) dut (
      .clock_pos(clock_pos),
      .reset_neg(reset_neg),
      .load_neg(load_neg),
      .load_value(load_value),
      .count_enable(count_enable),
      .count_up(count_up),
      .count_out(count_out),
      .terminal_count(terminal_count),
      .carry_pulse(carry_pulse),
      .signal_J(signal_J),
      .signal_K(signal_K)
   );

   always #5 clock_pos = ~clock_pos;

   always_ff @(posedge clock_pos) bank <= (signal_J & ~bank) | (~signal_K & bank);

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic rn, input logic ln, input logic [3:0] lv, input logic en, input logic up,
                       input int ec, input logic car, input logic tc,
                       input logic jchk, input logic [3:0] ej, input logic [3:0] ek);
      exp_t e;
      @(negedge clock_pos);
      reset_neg = rn;
      load_neg = ln;
      load_value = lv;
      count_enable = en;
      count_up = up;
      e.tc = tc;
      e.jchk = jchk;
      e.j = ej;
      e.k = ek;
      e.cnt = 4'(ec);
      e.car = car;
      q.push_back(e);
      if (tc) wraps++;
      mc = ec;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock_pos);
         #3;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("terminal_count", int'(terminal_count), int'(e.tc));
            if (e.jchk) begin
               chk("signal_J", int'(signal_J), int'(e.j));
               chk("signal_K", int'(signal_K), int'(e.k));
            end
            @(posedge clock_pos);
            #2;
            chk("count_out", int'(count_out), int'(e.cnt));
            chk("carry_pulse", int'(carry_pulse), int'(e.car));
            chk("jk_bank", int'(bank), int'(e.cnt));
            if (carry_pulse) car_seen++;
         end
      end
   end

   initial begin : driver
      int dn[7] = '{4, 3, 2, 1, 0, 9, 8};
      logic rn, ln, en, up, tc;
      logic [3:0] lv;
      int cl, nc;
      step(0, 1, 0, 1, 1, 0, 0, 0, 1, 4'h0, 4'hF);
      for (int i = 0; i < 12; i++)
         step(1, 1, 0, 1, 1, (i + 1) % 10, (i % 10) == 9, (i % 10) == 9,
              (i % 10) == 7 || (i % 10) == 9, (i % 10) == 7 ? 4'hF : 4'h9, (i % 10) == 7 ? 4'hF : 4'h9);
      step(1, 0, 5, 0, 1, 5, 0, 0, 1, 4'h5, 4'hA);
      for (int i = 0; i < 7; i++)
         step(1, 1, 0, 1, 0, dn[i], dn[i] == 9, dn[i] == 9, 0, 4'h0, 4'h0);
      step(1, 0, 14, 1, 0, 9, 0, 0, 1, 4'h9, 4'h6);
      step(1, 0, 3, 1, 1, 3, 0, 0, 1, 4'h3, 4'hC);
      step(1, 1, 0, 0, 1, 3, 0, 0, 1, 4'h0, 4'h0);
      for (int i = 4; i <= 7; i++) step(1, 1, 0, 1, 1, i, 0, 0, 0, 4'h0, 4'h0);
      step(0, 0, 5, 1, 1, 0, 0, 0, 1, 4'h0, 4'hF);
      step(1, 0, 9, 0, 1, 9, 0, 0, 1, 4'h9, 4'h6);
      step(1, 1, 0, 0, 1, 9, 0, 0, 1, 4'h0, 4'h0);
      step(1, 1, 0, 1, 0, 8, 0, 0, 1, 4'h1, 4'h1);
      step(1, 0, 9, 1, 1, 9, 0, 0, 0, 4'h0, 4'h0);
      step(1, 1, 0, 1, 1, 0, 1, 1, 1, 4'h9, 4'h9);
      step(1, 0, 6, 1, 1, 6, 0, 0, 1, 4'h6, 4'h9);
      step(1, 1, 0, 1, 1, 7, 0, 0, 1, 4'h1, 4'h1);
      for (int i = 0; i < 1000; i++) begin
         rn = ($urandom % 64) != 0;
         ln = ($urandom % 8) != 0;
         lv = 4'($urandom % 16);
         en = ($urandom % 4) != 0;
         up = 1'($urandom % 2);
         cl = (lv > 9) ? 9 : int'(lv);
         tc = rn && ln && en && (up ? mc == 9 : mc == 0);
         nc = !rn ? 0 : !ln ? cl : !en ? mc : up ? (mc + 1) % 10 : (mc + 9) % 10;
         step(rn, ln, lv, en, up, nc, tc, tc, 0, 4'h0, 4'h0);
      end
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock_pos);
      repeat (2) @(negedge clock_pos);
      chk("queue_drained", q.size(), 0);
      chk("carry_vs_wraps", car_seen, wraps);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end
endmodule
